// File: rtl/si5340_i2c_txn_engine.sv
// Si5340 register-transaction engine: turns one page/register access into the
// byte-command sequence for i2c_master_byte, inserting page-select writes as needed.
module si5340_i2c_txn_engine #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h74,
    parameter logic [7:0] PAGE_REG       = 8'h01,
    parameter int         GAP_CYCLES     = 4,
    parameter int         TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rw_i,
    input  logic [7:0] req_page_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_err_o,
    input  logic       page_inval_i,
    output logic       i2c_start_o,
    output logic       i2c_stop_o,
    output logic       i2c_read_o,
    output logic       i2c_write_o,
    output logic       i2c_ack_in_o,
    output logic [7:0] i2c_din_o,
    input  logic [7:0] i2c_dout_i,
    input  logic       i2c_ack_out_i,
    input  logic       i2c_cmd_ack_i,
    output logic       busy_o
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PG_ADDR, S_PG_REG, S_PG_DATA, S_ADDR_W, S_REG,
        S_WDATA, S_RS_ADDR, S_RDATA, S_ABORT, S_GAP, S_RESP
    } state_t;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       write;
        logic       ack_in;
        logic [7:0] din;
    } cmd_t;

    state_t          state, gap_next;
    cmd_t            cmd_q;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   to_cnt;
    logic            rw_q;
    logic [7:0]      page_q, reg_q, wdata_q;
    logic            cache_vld;
    logic [7:0]      cache_page;

    // Command word driven while sitting in a byte state.
    function automatic cmd_t cmd_for(state_t s, logic [7:0] pg, logic [7:0] rg, logic [7:0] wd);
        cmd_t c;
        c = '0;
        case (s)
            S_PG_ADDR, S_ADDR_W: begin c.start = 1'b1; c.write = 1'b1; c.din = {SLAVE_ADDR, 1'b0}; end
            S_PG_REG:  begin c.write = 1'b1; c.din = PAGE_REG; end
            S_PG_DATA: begin c.write = 1'b1; c.stop = 1'b1; c.din = pg; end
            S_REG:     begin c.write = 1'b1; c.din = rg; end
            S_WDATA:   begin c.write = 1'b1; c.stop = 1'b1; c.din = wd; end
            S_RS_ADDR: begin c.start = 1'b1; c.write = 1'b1; c.din = {SLAVE_ADDR, 1'b1}; end
            S_RDATA:   begin c.read = 1'b1; c.stop = 1'b1; c.ack_in = 1'b1; end
            S_ABORT:   c.stop = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_of(state_t s, logic rd);
        case (s)
            S_PG_ADDR: return S_PG_REG;
            S_PG_REG:  return S_PG_DATA;
            S_PG_DATA: return S_ADDR_W;
            S_ADDR_W:  return S_REG;
            S_REG:     return rd ? S_RS_ADDR : S_WDATA;
            S_RS_ADDR: return S_RDATA;
            default:   return S_IDLE;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state       <= S_IDLE;
            gap_next    <= S_IDLE;
            cmd_q       <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            rw_q        <= 1'b0;
            page_q      <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            cache_vld   <= 1'b0;
            cache_page  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: if (req_valid_i) begin
                    rw_q    <= req_rw_i;
                    page_q  <= req_page_i;
                    reg_q   <= req_reg_i;
                    wdata_q <= req_wdata_i;
                    to_cnt  <= '0;
                    if (cache_vld && !page_inval_i && cache_page == req_page_i) begin
                        state <= S_ADDR_W;
                        cmd_q <= cmd_for(S_ADDR_W, req_page_i, req_reg_i, req_wdata_i);
                    end else begin
                        state <= S_PG_ADDR;
                        cmd_q <= cmd_for(S_PG_ADDR, req_page_i, req_reg_i, req_wdata_i);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= gap_next;
                        cmd_q   <= cmd_for(gap_next, page_q, reg_q, wdata_q);
                        gap_cnt <= '0;
                        to_cnt  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: begin
                    if (i2c_cmd_ack_i) begin
                        cmd_q   <= '0;
                        to_cnt  <= '0;
                        gap_cnt <= '0;
                        if (i2c_ack_out_i && cmd_q.write) begin
                            cache_vld <= 1'b0;
                            // A NACKed command that already carries stop has released the bus.
                            if (cmd_q.stop) begin
                                state       <= S_RESP;
                                rsp_valid_o <= 1'b1;
                                rsp_err_o   <= 2'd1;
                                rsp_rdata_o <= '0;
                            end else begin
                                state    <= S_GAP;
                                gap_next <= S_ABORT;
                            end
                        end else begin
                            case (state)
                                S_RDATA: begin
                                    state       <= S_RESP;
                                    rsp_valid_o <= 1'b1;
                                    rsp_err_o   <= 2'd0;
                                    rsp_rdata_o <= i2c_dout_i;
                                end
                                S_WDATA, S_ABORT: begin
                                    state       <= S_RESP;
                                    rsp_valid_o <= 1'b1;
                                    rsp_err_o   <= (state == S_ABORT) ? 2'd1 : 2'd0;
                                    rsp_rdata_o <= '0;
                                end
                                default: begin
                                    if (state == S_PG_DATA) begin
                                        cache_vld  <= 1'b1;
                                        cache_page <= page_q;
                                    end
                                    state    <= S_GAP;
                                    gap_next <= next_of(state, rw_q);
                                end
                            endcase
                        end
                    end else if (to_cnt == TO_LAST) begin
                        // Controller is unresponsive; drop the bus without a stop.
                        state       <= S_RESP;
                        cmd_q       <= '0;
                        to_cnt      <= '0;
                        cache_vld   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 2'd2;
                        rsp_rdata_o <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase
            if (page_inval_i) cache_vld <= 1'b0;
        end
    end

    assign req_ready_o  = arstn_i && (state == S_IDLE);
    assign busy_o       = (state != S_IDLE);
    assign i2c_start_o  = cmd_q.start;
    assign i2c_stop_o   = cmd_q.stop;
    assign i2c_read_o   = cmd_q.read;
    assign i2c_write_o  = cmd_q.write;
    assign i2c_ack_in_o = cmd_q.ack_in;
    assign i2c_din_o    = cmd_q.din;

endmodule
